// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake and data bundle between the fetch/regfile side,
// the alu_issue stage and the execute stage.
// The o_illegal signal exists only when ALU_ISSUE_ILLEGAL_EN is defined.
interface alu_issue_if;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_inst;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_rdata;
    logic [31:0] i_rs2_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_opsel;
    logic        o_sub;
    logic        o_unsigned;
    logic        o_arith;
    logic [31:0] o_op1;
    logic [31:0] o_op2;
    logic [31:0] o_pc;
    logic [2:0]  o_funct3;
    logic [4:0]  o_rd;
    logic        o_wen;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        o_illegal;
`endif

    // Issue-stage view.
    modport slave (
        input  i_flush, i_valid, i_inst, i_pc, i_rs1_rdata, i_rs2_rdata, i_ready,
        output o_ready, o_valid, o_opsel, o_sub, o_unsigned, o_arith,
               o_op1, o_op2, o_pc, o_funct3, o_rd, o_wen
`ifdef ALU_ISSUE_ILLEGAL_EN
        , output o_illegal
`endif
    );

    // Upstream/downstream view (what drives the stage and consumes it).
    modport master (
        output i_flush, i_valid, i_inst, i_pc, i_rs1_rdata, i_rs2_rdata, i_ready,
        input  o_ready, o_valid, o_opsel, o_sub, o_unsigned, o_arith,
               o_op1, o_op2, o_pc, o_funct3, o_rd, o_wen
`ifdef ALU_ISSUE_ILLEGAL_EN
        , input o_illegal
`endif
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode-and-issue stage. Decodes the instruction
// combinationally into ALU controls and operands, then holds the result in a
// registered valid/ready slot backed by a one-entry skid buffer.
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN (adds the o_illegal flag).
module alu_issue (
    input  logic         i_clk,
    input  logic         i_rst,
    alu_issue_if.slave   bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Everything the execute stage needs; only decoded values are stored.
    typedef struct packed {
        logic [2:0]  opsel;
        logic        sub;
        logic        is_unsigned;
        logic        arith;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        wen;
`ifdef ALU_ISSUE_ILLEGAL_EN
        logic        illegal;
`endif
    } issue_t;

    issue_t dec;
    issue_t slot_reg, slot_next;
    issue_t skid_reg, skid_next;
    logic   slot_valid_reg, slot_valid_next;
    logic   skid_valid_reg, skid_valid_next;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        accept;
    logic        drain;

    assign opcode = bus.i_inst[6:0];
    assign funct3 = bus.i_inst[14:12];
    assign funct7 = bus.i_inst[31:25];
    assign rd     = bus.i_inst[11:7];
    assign imm_i  = {{20{bus.i_inst[31]}}, bus.i_inst[31:20]};
    assign imm_s  = {{20{bus.i_inst[31]}}, bus.i_inst[31:25], bus.i_inst[11:7]};
    assign imm_u  = {bus.i_inst[31:12], 12'b0};
    assign shamt  = {27'b0, bus.i_inst[24:20]};

    // o_ready is registered: it is simply "skid entry empty".
    assign accept = bus.i_valid & ~skid_valid_reg;
    assign drain  = slot_valid_reg & bus.i_ready;

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic dec_illegal;

    // Flag encodings that are not legal RV32I; the decode itself is unaffected.
    always_comb begin
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0100000)
                    dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
                else
                    dec_illegal = (funct7 != 7'b0000000);
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001)
                    dec_illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    dec_illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
            end
            OPC_BRANCH: dec_illegal = (funct3[2:1] == 2'b01);
            OPC_JALR:   dec_illegal = (funct3 != 3'b000);
            OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JAL: dec_illegal = 1'b0;
            default:    dec_illegal = 1'b1;
        endcase
        if (bus.i_inst[1:0] != 2'b11)
            dec_illegal = 1'b1;
    end
`endif

    // Opcode decode into ALU controls and operands; unknown opcodes become 0+0.
    always_comb begin
        dec        = '0;
        dec.pc     = bus.i_pc;
        dec.funct3 = funct3;
        dec.rd     = rd;
        case (opcode)
            OPC_OP: begin
                dec.opsel       = funct3;
                dec.sub         = bus.i_inst[30] & (funct3 == 3'b000);
                dec.arith       = bus.i_inst[30] & (funct3 == 3'b101);
                dec.is_unsigned = (funct3 == 3'b011);
                dec.op1         = bus.i_rs1_rdata;
                dec.op2         = bus.i_rs2_rdata;
                dec.wen         = (rd != 5'd0);
            end
            OPC_OP_IMM: begin
                dec.opsel       = funct3;
                dec.arith       = bus.i_inst[30] & (funct3 == 3'b101);
                dec.is_unsigned = (funct3 == 3'b011);
                dec.op1         = bus.i_rs1_rdata;
                // Shift amounts come from the low five immediate bits only.
                dec.op2         = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
                dec.wen         = (rd != 5'd0);
            end
            OPC_LUI: begin
                dec.op2 = imm_u;
                dec.wen = (rd != 5'd0);
            end
            OPC_AUIPC: begin
                dec.op1 = bus.i_pc;
                dec.op2 = imm_u;
                dec.wen = (rd != 5'd0);
            end
            OPC_LOAD: begin
                dec.op1 = bus.i_rs1_rdata;
                dec.op2 = imm_i;
                dec.wen = (rd != 5'd0);
            end
            OPC_STORE: begin
                dec.op1 = bus.i_rs1_rdata;
                dec.op2 = imm_s;
            end
            OPC_BRANCH: begin
                // Compare via subtract; execute reads eq/slt from the ALU.
                dec.sub         = 1'b1;
                dec.is_unsigned = funct3[1];
                dec.op1         = bus.i_rs1_rdata;
                dec.op2         = bus.i_rs2_rdata;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces the link value pc+4.
                dec.op1 = bus.i_pc;
                dec.op2 = 32'd4;
                dec.wen = (rd != 5'd0);
            end
            default: begin
                dec.op1 = 32'd0;
                dec.op2 = 32'd0;
            end
        endcase
`ifdef ALU_ISSUE_ILLEGAL_EN
        dec.illegal = dec_illegal;
`endif
    end

    // Slot/skid next state: skid refills the slot first, new decodes go to the
    // slot when it frees up, or park in the skid while the slot is held.
    always_comb begin
        slot_next       = slot_reg;
        skid_next       = skid_reg;
        slot_valid_next = slot_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (bus.i_flush) begin
            slot_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!slot_valid_reg || drain) begin
            if (skid_valid_reg) begin
                slot_next       = skid_reg;
                slot_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                slot_next       = dec;
                slot_valid_next = 1'b1;
            end else begin
                slot_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_next       = dec;
            skid_valid_next = 1'b1;
        end
    end

    // State registers; reset clears data too so all outputs read zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_reg       <= '0;
            skid_reg       <= '0;
            slot_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            slot_reg       <= slot_next;
            skid_reg       <= skid_next;
            slot_valid_reg <= slot_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    assign bus.o_ready    = ~skid_valid_reg;
    assign bus.o_valid    = slot_valid_reg;
    assign bus.o_opsel    = slot_reg.opsel;
    assign bus.o_sub      = slot_reg.sub;
    assign bus.o_unsigned = slot_reg.is_unsigned;
    assign bus.o_arith    = slot_reg.arith;
    assign bus.o_op1      = slot_reg.op1;
    assign bus.o_op2      = slot_reg.op2;
    assign bus.o_pc       = slot_reg.pc;
    assign bus.o_funct3   = slot_reg.funct3;
    assign bus.o_rd       = slot_reg.rd;
    assign bus.o_wen      = slot_reg.wen;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign bus.o_illegal  = slot_reg.illegal;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed-vector bench for alu_issue with hand-computed
// expected values. Checks decode, backpressure/skid, flush and reset.
// Honors ALU_ISSUE_ILLEGAL_EN for the o_illegal checks.
module tb_alu_issue;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.i_valid     = v;
        bus.i_inst      = inst;
        bus.i_pc        = pc;
        bus.i_rs1_rdata = rs1;
        bus.i_rs2_rdata = rs2;
    endtask

    task automatic expect_issue(input string tag, input logic [2:0] opsel, input logic sub,
                                input logic uns, input logic arith, input logic [31:0] op1,
                                input logic [31:0] op2, input logic [4:0] rd, input logic wen);
        $display("txn %s: valid=%0d opsel=%0d sub=%0d uns=%0d arith=%0d op1=0x%08h op2=0x%08h rd=%0d wen=%0d",
                 tag, bus.o_valid, bus.o_opsel, bus.o_sub, bus.o_unsigned, bus.o_arith,
                 bus.o_op1, bus.o_op2, bus.o_rd, bus.o_wen);
        check_value({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
        check_value({tag, ".opsel"}, 32'(bus.o_opsel), 32'(opsel));
        check_value({tag, ".sub"}, 32'(bus.o_sub), 32'(sub));
        check_value({tag, ".unsigned"}, 32'(bus.o_unsigned), 32'(uns));
        check_value({tag, ".arith"}, 32'(bus.o_arith), 32'(arith));
        check_value({tag, ".op1"}, bus.o_op1, op1);
        check_value({tag, ".op2"}, bus.o_op2, op2);
        check_value({tag, ".rd"}, 32'(bus.o_rd), 32'(rd));
        check_value({tag, ".wen"}, 32'(bus.o_wen), 32'(wen));
    endtask

    initial begin
        int seen;
        rst         = 1'b1;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_value("rst.valid", 32'(bus.o_valid), 32'd0);
        check_value("rst.ready", 32'(bus.o_ready), 32'd1);
        check_value("rst.op1", bus.o_op1, 32'd0);
        check_value("rst.op2", bus.o_op2, 32'd0);
        check_value("rst.opsel", 32'(bus.o_opsel), 32'd0);
        check_value("rst.wen", 32'(bus.o_wen), 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        check_value("rst.illegal", 32'(bus.o_illegal), 32'd0);
`endif

        // Back-to-back decode vectors with i_ready=1 (one per cycle)
        drive(1'b1, 32'h00B50533, 32'h0, 32'd5, 32'd7);            // add x10,x10,x11
        step();
        expect_issue("add", 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 5'd10, 1'b1);
        check_value("add.funct3", 32'(bus.o_funct3), 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        check_value("add.illegal", 32'(bus.o_illegal), 32'd0);
`endif
        drive(1'b1, 32'h40335293, 32'h4, 32'h000000F0, 32'h55);    // srai x5,x6,3
        step();
        expect_issue("srai", 3'b101, 1'b0, 1'b0, 1'b1, 32'h000000F0, 32'd3, 5'd5, 1'b1);
        drive(1'b1, 32'hFFF13093, 32'h8, 32'h10, 32'h0);           // sltiu x1,x2,-1
        step();
        expect_issue("sltiu", 3'b011, 1'b0, 1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 5'd1, 1'b1);
        drive(1'b1, 32'h12345197, 32'h100, 32'h77, 32'h66);        // auipc x3,0x12345
        step();
        expect_issue("auipc", 3'b000, 1'b0, 1'b0, 1'b0, 32'h100, 32'h12345000, 5'd3, 1'b1);
        check_value("auipc.pc", bus.o_pc, 32'h100);
        drive(1'b1, 32'h0020E463, 32'h104, 32'd3, 32'd9);          // bltu x1,x2,+8
        step();
        expect_issue("bltu", 3'b000, 1'b1, 1'b1, 1'b0, 32'd3, 32'd9, 5'd8, 1'b0);
        check_value("bltu.funct3", 32'(bus.o_funct3), 32'd6);
        drive(1'b1, 32'h40628233, 32'h108, 32'h20, 32'h8);         // sub x4,x5,x6
        step();
        expect_issue("sub", 3'b000, 1'b1, 1'b0, 1'b0, 32'h20, 32'h8, 5'd4, 1'b1);
        drive(1'b1, 32'hABCDE3B7, 32'h10C, 32'hDEAD, 32'hBEEF);    // lui x7,0xABCDE
        step();
        expect_issue("lui", 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'hABCDE000, 5'd7, 1'b1);
        drive(1'b1, 32'hFE20AE23, 32'h110, 32'h1000, 32'h5);       // sw x2,-4(x1)
        step();
        expect_issue("sw", 3'b000, 1'b0, 1'b0, 1'b0, 32'h1000, 32'hFFFFFFFC, 5'd28, 1'b0);
        drive(1'b1, 32'h008000EF, 32'h200, 32'h1, 32'h2);          // jal x1,+8
        step();
        expect_issue("jal", 3'b000, 1'b0, 1'b0, 1'b0, 32'h200, 32'd4, 5'd1, 1'b1);
        drive(1'b1, 32'hFFFFFFFF, 32'h204, 32'h1234, 32'h5678);    // illegal word
        step();
        expect_issue("ffff", 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd31, 1'b0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        check_value("ffff.illegal", 32'(bus.o_illegal), 32'd1);
`endif
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        check_value("idle.valid", 32'(bus.o_valid), 32'd0);

        // Backpressure: slot holds #1, skid holds #2, #3 refused
        bus.i_ready = 1'b0;
        drive(1'b1, 32'h00B50533, 32'h300, 32'd1, 32'd0);
        step();
        check_value("bp1.op1", bus.o_op1, 32'd1);
        check_value("bp1.ready", 32'(bus.o_ready), 32'd1);
        drive(1'b1, 32'h00B50533, 32'h304, 32'd2, 32'd0);
        step();
        check_value("bp2.op1", bus.o_op1, 32'd1);
        check_value("bp2.ready", 32'(bus.o_ready), 32'd0);
        drive(1'b1, 32'h00B50533, 32'h308, 32'd3, 32'd0);
        step();
        check_value("bp3.op1", bus.o_op1, 32'd1);
        check_value("bp3.ready", 32'(bus.o_ready), 32'd0);
        check_value("bp3.valid", 32'(bus.o_valid), 32'd1);
        $display("txn bp: held op1=%0d ready=%0d", bus.o_op1, bus.o_ready);
        bus.i_ready = 1'b1;                                        // #1 drains, #2 moves up
        step();
        check_value("bpd2.op1", bus.o_op1, 32'd2);
        check_value("bpd2.pc", bus.o_pc, 32'h304);
        check_value("bpd2.ready", 32'(bus.o_ready), 32'd1);
        step();                                                    // #3 accepted while #2 drains
        check_value("bpd3.op1", bus.o_op1, 32'd3);
        check_value("bpd3.valid", 32'(bus.o_valid), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        check_value("bpd.empty", 32'(bus.o_valid), 32'd0);
        $display("txn bp-drain: done valid=%0d", bus.o_valid);

        // Flush with an accept in the same cycle (skid empty, o_ready=1)
        bus.i_flush = 1'b1;
        drive(1'b1, 32'h00B50533, 32'h400, 32'd9, 32'd9);
        step();
        bus.i_flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        check_value("fl0.valid", 32'(bus.o_valid), 32'd0);

        // Flush with slot and skid full
        bus.i_ready = 1'b0;
        drive(1'b1, 32'h00B50533, 32'h500, 32'h11, 32'd0);
        step();
        drive(1'b1, 32'h00B50533, 32'h504, 32'h22, 32'd0);
        step();
        check_value("fl.full", 32'(bus.o_ready), 32'd0);
        bus.i_flush = 1'b1;
        drive(1'b1, 32'h00B50533, 32'h508, 32'h33, 32'd0);
        step();
        bus.i_flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        check_value("fl.valid", 32'(bus.o_valid), 32'd0);
        check_value("fl.ready", 32'(bus.o_ready), 32'd1);
        bus.i_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.o_valid) seen++;
        end
        check_value("fl.after", 32'(seen), 32'd0);
        $display("txn flush: issued_after=%0d", seen);

        // Reset mid-operation clears outputs
        bus.i_ready = 1'b0;
        drive(1'b1, 32'h00B50533, 32'h600, 32'd5, 32'd7);
        step();
        check_value("mr.pre", bus.o_op1, 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        check_value("mr.valid", 32'(bus.o_valid), 32'd0);
        check_value("mr.op1", bus.o_op1, 32'd0);
        check_value("mr.rd", 32'(bus.o_rd), 32'd0);
        check_value("mr.ready", 32'(bus.o_ready), 32'd1);
        $display("txn midreset: valid=%0d op1=0x%08h", bus.o_valid, bus.o_op1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
